video_tx_timing: RTL and testbench

// - Video transmitter on vo_clk: generates HDMI-style timing (vsync/hsync/de/data) and drives the vo_* pins.
// - Outputs a colour-bar background with a 32x32 8-bit grey window read from a dual-port 1024x8 buffer.
// - The window is each buffer pixel replicated SCALE x SCALE.
// - Read side of the same buffer layout the capture path writes (row-major, addr = {row[4:0], col[4:0]}).

---
 rtl/video_tx_timing_pkg.sv | 44 ++++
 rtl/video_timing_cnt.sv | 75 +++++++
 rtl/video_tx_timing.sv | 126 ++++++++++++
 tb/tb_video_tx_timing.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/video_tx_timing_pkg.sv
// video_tx_timing_pkg: shared constants, S1 pipeline record and colour-bar lookup for the video transmitter.
package video_tx_timing_pkg;

    localparam int W_HDMITX = 24;

    localparam bit VID_SYNC_POS = 1'b1;
    localparam bit VID_SYNC_NEG = 1'b0;

    localparam logic [W_HDMITX-1:0] VID_RGB_WHITE   = 24'hFFFFFF;
    localparam logic [W_HDMITX-1:0] VID_RGB_YELLOW  = 24'hFFFF00;
    localparam logic [W_HDMITX-1:0] VID_RGB_CYAN    = 24'h00FFFF;
    localparam logic [W_HDMITX-1:0] VID_RGB_GREEN   = 24'h00FF00;
    localparam logic [W_HDMITX-1:0] VID_RGB_MAGENTA = 24'hFF00FF;
    localparam logic [W_HDMITX-1:0] VID_RGB_RED     = 24'hFF0000;
    localparam logic [W_HDMITX-1:0] VID_RGB_BLUE    = 24'h0000FF;
    localparam logic [W_HDMITX-1:0] VID_RGB_BLACK   = 24'h000000;

    // Timing and window state carried from the counter cycle to the pin stage.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       hit;
        logic       fs;
        logic [3:0] bar;
    } vid_s1_t;

    // Bar index 8 and above marks the remainder pixels right of the last full bar.
    function automatic logic [W_HDMITX-1:0] vid_bar_rgb(input logic [3:0] idx);
        logic [W_HDMITX-1:0] c;
        case (idx[2:0])
            3'd0:    c = VID_RGB_WHITE;
            3'd1:    c = VID_RGB_YELLOW;
            3'd2:    c = VID_RGB_CYAN;
            3'd3:    c = VID_RGB_GREEN;
            3'd4:    c = VID_RGB_MAGENTA;
            3'd5:    c = VID_RGB_RED;
            3'd6:    c = VID_RGB_BLUE;
            default: c = VID_RGB_BLACK;
        endcase
        return idx[3] ? VID_RGB_BLACK : c;
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// video_timing_cnt: h/v raster counters with sync/de decode and frame-boundary run gating.
//   vo_clk, rstn    clock, async active-low reset
//   en              run request, honoured only at a frame boundary or while stopped
//   h, v            current raster position (held at 0 while stopped)
//   running         counters are live
//   hs, vs, de      decoded sync levels and data enable for the current position
//   first           current position is (0,0) of a running frame
//   line_end        current position is the last pixel of a line
module video_timing_cnt import video_tx_timing_pkg::*; #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = VID_SYNC_POS,
    parameter bit VS_POL   = VID_SYNC_POS,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          vo_clk,
    input  logic          rstn,
    input  logic          en,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          running,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          first,
    output logic          line_end
);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          running_q, running_d;
    logic          h_last, v_last;

    always_comb begin
        h_last    = h_q == HW'(H_TOTAL - 1);
        v_last    = v_q == VW'(V_TOTAL - 1);
        // Run state only changes when (0,0) is next, so a stop always lets the frame finish.
        running_d = (!running_q || (h_last && v_last)) ? en : running_q;
        h_d       = (!running_q || h_last) ? '0 : h_q + 1'b1;
        v_d       = !running_q ? '0 : h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;
    end

    always_ff @(posedge vo_clk or negedge rstn) begin
        if (!rstn) begin
            h_q       <= '0;
            v_q       <= '0;
            running_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        h        = h_q;
        v        = v_q;
        running  = running_q;
        line_end = h_last;
        first    = running_q && h_q == '0 && v_q == '0;
        de       = running_q && h_q < HW'(H_ACTIVE) && v_q < VW'(V_ACTIVE);
        hs       = (running_q && h_q >= HW'(H_ACTIVE + H_FP) && h_q < HW'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
        vs       = (running_q && v_q >= VW'(V_ACTIVE + V_FP) && v_q < VW'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
    end

endmodule

// File: rtl/video_tx_timing.sv
// video_tx_timing: HDMI-style transmitter; colour bars with a scaled 32x32 grey window from a 1024x8 buffer.
//   vo_clk, rstn        pixel clock, async active-low reset
//   en                  run enable, sampled at frame boundary
//   cena_buf, aa_buf    buffer read enable (active low) and address {row, col}
//   qa_buf              buffer read data, one cycle after the read
//   vo_vsync, vo_hsync  sync outputs
//   vo_de, vo_data      data enable and {R,G,B} pixel
//   frame_start         pulse with the first pixel of each frame
module video_tx_timing import video_tx_timing_pkg::*; #(
    parameter int H_ACTIVE   = 1920,
    parameter int H_FP       = 88,
    parameter int H_SYNC     = 44,
    parameter int H_BP       = 148,
    parameter int V_ACTIVE   = 1080,
    parameter int V_FP       = 4,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 36,
    parameter bit HS_POL     = VID_SYNC_POS,
    parameter bit VS_POL     = VID_SYNC_POS,
    parameter int W_DATA     = W_HDMITX,
    parameter int WIN_X      = 960,
    parameter int WIN_Y      = 540,
    parameter int SCALE_LOG2 = 2
) (
    input  logic              vo_clk,
    input  logic              rstn,
    input  logic              en,
    output logic              cena_buf,
    output logic [9:0]        aa_buf,
    input  logic [7:0]        qa_buf,
    output logic              vo_vsync,
    output logic              vo_hsync,
    output logic              vo_de,
    output logic [W_DATA-1:0] vo_data,
    output logic              frame_start
);

    localparam int HW     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int WIN_SZ = 32 << SCALE_LOG2;
    localparam int BAR_W  = H_ACTIVE >> 3;
    localparam int PW     = BAR_W > 1 ? $clog2(BAR_W) : 1;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          running, hs, vs, de, first, line_end;

    video_timing_cnt #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) u_cnt (
        .vo_clk(vo_clk), .rstn(rstn), .en(en),
        .h(h), .v(v), .running(running),
        .hs(hs), .vs(vs), .de(de), .first(first), .line_end(line_end)
    );

    logic [31:0]       dx, dy;
    logic              hit;
    logic [9:0]        aa_q, aa_d;
    logic [PW-1:0]     bar_px_q, bar_px_d;
    logic [3:0]        bar_idx_q, bar_idx_d;
    logic              bar_wrap;
    vid_s1_t           s1_q, s1_d;
    logic              vo_vsync_q, vo_vsync_d, vo_hsync_q, vo_hsync_d;
    logic              vo_de_q, vo_de_d, frame_start_q, frame_start_d;
    logic [W_DATA-1:0] vo_data_q, vo_data_d;

    // The read is issued in the counter cycle so the sync-RAM data is ready for the pin stage.
    // Unsigned offsets wrap to huge values left/above the window, so one compare covers both edges.
    always_comb begin
        dx       = 32'(h) - 32'(WIN_X);
        dy       = 32'(v) - 32'(WIN_Y);
        hit      = de && dx < 32'(WIN_SZ) && dy < 32'(WIN_SZ);
        cena_buf = ~hit;
        aa_buf   = hit ? {dy[SCALE_LOG2 +: 5], dx[SCALE_LOG2 +: 5]} : aa_q;
        aa_d     = aa_buf;
    end

    // Bar index tracks h by counting BAR_W pixels at a time; it saturates at 8 for the black remainder.
    always_comb begin
        bar_wrap  = bar_px_q == PW'(BAR_W - 1);
        bar_px_d  = (!running || line_end || bar_wrap) ? '0 : bar_px_q + 1'b1;
        bar_idx_d = (!running || line_end) ? '0 : (bar_wrap && !bar_idx_q[3]) ? bar_idx_q + 1'b1 : bar_idx_q;
    end

    always_comb begin
        s1_d          = '{de: de, hs: hs, vs: vs, hit: hit, fs: first, bar: bar_idx_q};
        vo_de_d       = s1_q.de;
        vo_hsync_d    = s1_q.hs;
        vo_vsync_d    = s1_q.vs;
        frame_start_d = s1_q.fs;
        vo_data_d     = !s1_q.de ? '0 : s1_q.hit ? W_DATA'({qa_buf, qa_buf, qa_buf}) : W_DATA'(vid_bar_rgb(s1_q.bar));
    end

    always_ff @(posedge vo_clk or negedge rstn) begin
        if (!rstn) begin
            aa_q          <= '0;
            bar_px_q      <= '0;
            bar_idx_q     <= '0;
            s1_q          <= '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, hit: 1'b0, fs: 1'b0, bar: 4'd0};
            vo_de_q       <= 1'b0;
            vo_hsync_q    <= ~HS_POL;
            vo_vsync_q    <= ~VS_POL;
            frame_start_q <= 1'b0;
            vo_data_q     <= '0;
        end else begin
            aa_q          <= aa_d;
            bar_px_q      <= bar_px_d;
            bar_idx_q     <= bar_idx_d;
            s1_q          <= s1_d;
            vo_de_q       <= vo_de_d;
            vo_hsync_q    <= vo_hsync_d;
            vo_vsync_q    <= vo_vsync_d;
            frame_start_q <= frame_start_d;
            vo_data_q     <= vo_data_d;
        end
    end

    assign vo_de       = vo_de_q;
    assign vo_hsync    = vo_hsync_q;
    assign vo_vsync    = vo_vsync_q;
    assign frame_start = frame_start_q;
    assign vo_data     = vo_data_q;

endmodule

// File: tb/tb_video_tx_timing.sv
// tb_video_tx_timing: directed self-checking bench for video_tx_timing on a 22x11 raster.
module tb_video_tx_timing;

    logic        vo_clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        cena_buf;
    logic [9:0]  aa_buf;
    logic [7:0]  qa_buf = 8'h00;
    logic        vo_vsync, vo_hsync, vo_de, frame_start;
    logic [23:0] vo_data;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;
    int n_de, n_fs, n_hs, n_vs, n_rd;

    localparam int FR = 242;

    video_tx_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .W_DATA(24),
        .WIN_X(4), .WIN_Y(2), .SCALE_LOG2(0)
    ) dut (
        .vo_clk(vo_clk), .rstn(rstn), .en(en),
        .cena_buf(cena_buf), .aa_buf(aa_buf), .qa_buf(qa_buf),
        .vo_vsync(vo_vsync), .vo_hsync(vo_hsync), .vo_de(vo_de),
        .vo_data(vo_data), .frame_start(frame_start)
    );

    always #5 vo_clk = ~vo_clk;

    // Buffer content model: each location holds the low byte of its address.
    always @(posedge vo_clk) if (!cena_buf) qa_buf <= aa_buf[7:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vo_clk);
        #1;
        pos++;
    endtask

    // pos counts edges since the counters left (0,0); pins lag the counters by two cycles.
    task automatic go_pin(input int f, input int h, input int v);
        while (pos < f * FR + v * 22 + h + 2) step();
    endtask

    task automatic go_cnt(input int f, input int h, input int v);
        while (pos < f * FR + v * 22 + h) step();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vs"}, 32'(vo_vsync), 32'd0);
        chk({tag, "_hs"}, 32'(vo_hsync), 32'd1);
        chk({tag, "_de"}, 32'(vo_de), 32'd0);
        chk({tag, "_data"}, 32'(vo_data), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_cena"}, 32'(cena_buf), 32'd1);
        chk({tag, "_aa"}, 32'(aa_buf), 32'd0);
    endtask

    task automatic start();
        @(posedge vo_clk);
        #1;
        pos = 0;
    endtask

    task automatic frame_stats();
        n_de = 0; n_fs = 0; n_hs = 0; n_vs = 0; n_rd = 0;
        for (int i = 0; i < FR; i++) begin
            n_de += int'(vo_de);
            n_fs += int'(frame_start);
            n_hs += int'(!vo_hsync);
            n_vs += int'(vo_vsync);
            n_rd += int'(!cena_buf);
            step();
        end
    endtask

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        repeat (3) @(posedge vo_clk);
        #1;
        chk_idle("reset");
        rstn = 1'b1;
        repeat (3) @(posedge vo_clk);
        #1;
        chk_idle("stopped");

        en = 1'b1;
        start();
        chk("de_lat0", 32'(vo_de), 32'd0);
        step();
        chk("de_lat1", 32'(vo_de), 32'd0);
        step();
        chk("first_de", 32'(vo_de), 32'd1);
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("bar_h0", 32'(vo_data), 32'hFFFFFF);
        chk("hs_h0", 32'(vo_hsync), 32'd1);
        go_pin(0, 1, 0);
        chk("fs_pulse", 32'(frame_start), 32'd0);
        chk("bar_h1", 32'(vo_data), 32'hFFFFFF);
        go_pin(0, 2, 0);  chk("bar_h2", 32'(vo_data), 32'hFFFF00);
        go_pin(0, 4, 0);  chk("bar_h4", 32'(vo_data), 32'h00FFFF);
        go_pin(0, 12, 0); chk("bar_h12", 32'(vo_data), 32'h0000FF);
        go_pin(0, 14, 0);
        chk("bar_h14", 32'(vo_data), 32'h000000);
        chk("de_h14", 32'(vo_de), 32'd1);
        go_pin(0, 16, 0);
        chk("blank_de", 32'(vo_de), 32'd0);
        chk("blank_data", 32'(vo_data), 32'd0);
        go_pin(0, 17, 0); chk("hs_h17", 32'(vo_hsync), 32'd1);
        go_pin(0, 18, 0); chk("hs_h18", 32'(vo_hsync), 32'd0);
        go_pin(0, 20, 0); chk("hs_h20", 32'(vo_hsync), 32'd1);
        go_pin(0, 8, 1);  chk("bar_h8", 32'(vo_data), 32'hFF00FF);
        go_pin(0, 3, 2);  chk("left_of_win", 32'(vo_data), 32'hFFFF00);
        go_pin(0, 4, 2);  chk("win_corner", 32'(vo_data), 32'h000000);
        go_cnt(0, 5, 3);
        chk("win_aa", 32'(aa_buf), 32'h021);
        chk("win_cena", 32'(cena_buf), 32'd0);
        go_pin(0, 5, 3);  chk("win_data", 32'(vo_data), 32'h212121);
        go_pin(0, 15, 7); chk("win_last", 32'(vo_data), 32'hABABAB);
        go_pin(0, 16, 7);
        chk("win_clip_de", 32'(vo_de), 32'd0);
        chk("win_clip_data", 32'(vo_data), 32'd0);
        go_pin(0, 21, 8); chk("vs_pre", 32'(vo_vsync), 32'd0);
        go_pin(0, 0, 9);  chk("vs_start", 32'(vo_vsync), 32'd1);
        go_pin(0, 21, 9); chk("vs_end", 32'(vo_vsync), 32'd1);
        go_pin(0, 0, 10); chk("vs_post", 32'(vo_vsync), 32'd0);

        go_pin(1, 0, 0);
        frame_stats();
        chk("frame_de", 32'(n_de), 32'd128);
        chk("frame_fs", 32'(n_fs), 32'd1);
        chk("frame_hs_low", 32'(n_hs), 32'd22);
        chk("frame_vs", 32'(n_vs), 32'd22);
        chk("frame_reads", 32'(n_rd), 32'd72);

        en = 1'b0;
        go_pin(2, 15, 7);
        chk("stop_completes_de", 32'(vo_de), 32'd1);
        chk("stop_completes_data", 32'(vo_data), 32'hABABAB);
        go_pin(3, 0, 0);
        frame_stats();
        chk("stopped_de", 32'(n_de), 32'd0);
        chk("stopped_fs", 32'(n_fs), 32'd0);
        chk("stopped_hs", 32'(n_hs), 32'd0);
        chk("stopped_reads", 32'(n_rd), 32'd0);

        en = 1'b1;
        start();
        step();
        chk("resume_lat", 32'(vo_de), 32'd0);
        step();
        chk("resume_fs", 32'(frame_start), 32'd1);
        chk("resume_data", 32'(vo_data), 32'hFFFFFF);

        go_pin(0, 8, 4);
        chk("pre_rst_cena", 32'(cena_buf), 32'd0);
        chk("pre_rst_de", 32'(vo_de), 32'd1);
        rstn = 1'b0;
        #1;
        chk_idle("midrst");
        #2;
        rstn = 1'b1;
        start();
        step();
        step();
        chk("rst_restart_fs", 32'(frame_start), 32'd1);
        chk("rst_restart_de", 32'(vo_de), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
